product_accumulator: RTL and testbench
======================================

# product_accumulator

Sequential accumulator directly downstream of the 2-bit multiplier. It consumes the 4-bit products {P3,P2,P1,P0} one per accepted beat and sums a frame of LEN products into an ACC_W-bit result. It presents the result over a valid/ready handshake, and flags overflow. Typical use: dot products of 2-bit vectors built from the combinational multiplier.

## Interface
- ACC_W, default 8: accumulator and result width; legal range 5..16.
- LEN, default 4: products per frame; legal range 1..15.
- clk  input  1  rising-edge clock.
- rst  input  1  reset; synchronous, active-high.
- clr  input  1  synchronous frame abort; priority below rst, above all else.
- in_valid  input  1  product beat valid.
- in_ready  output  1  accumulator can take a beat.
- P  input  4  product {P3,P2,P1,P0} from the multiplier; unsigned 0..9.
- out_valid  output  1  frame result valid.
- out_ready  input  1  consumer takes the result.
- sum  output  ACC_W  accumulated result.
- ovf  output  1  frame overflowed (wrap or saturate).

## Operation
- Registers:
  - state: ACCUM or HOLD.
  - acc: ACC_W bits.
  - cnt: 4 bits.
  - ovf: sticky per frame.
- in_ready = (state==ACCUM) && !rst.
- out_valid = (state==HOLD).
- sum = acc at all times. It is meaningful only while out_valid=1.
- ACCUM:
  - Accept when in_valid && in_ready.
  - On accept: acc <= acc + zero-extended P; cnt <= cnt + 1.
  - If cnt==LEN-1 on accept, go to HOLD with the final sum in acc.
  - in_valid low: no change.
- HOLD:
  - No beats accepted.
  - acc, cnt and ovf hold while out_ready=0.
  - On out_ready=1: go to ACCUM; acc <= 0, cnt <= 0, ovf <= 0.
- Arithmetic: the add is computed ACC_W+1 wide. A carry out sets ovf (sticky until the frame is consumed or cleared). Result handling on carry is per Configuration.
- clr=1 (any state): state <= ACCUM, acc <= 0, cnt <= 0, ovf <= 0. Any beat presented that cycle is dropped, and any pending result is discarded.
- rst=1: same register values as clr. in_ready is forced 0 during the reset cycle(s).
- P values 10..15 cannot come from the multiplier. They are still added as given; no checking.

## Timing
- Reset values: state=ACCUM, acc=0, cnt=0, ovf=0, out_valid=0, sum=0. in_ready=0 while rst is high and 1 the first cycle after.
- Throughput: one product per clock in ACCUM.
- Latency: out_valid rises the cycle after the LEN-th accepted beat; sum and ovf are valid in that same cycle.
- Result acceptance: the result is consumed on the edge where out_valid && out_ready. in_ready rises the following cycle. Minimum frame period is LEN+1 cycles.
- out_valid, once high, stays high with sum/ovf stable until consumed, clr, or rst.
- Simultaneous events:
  - clr with an accepting beat: clr wins.
  - clr with a consuming out_ready: clr wins (same end state).
  - rst beats everything.
- LEN=1: every accepted beat goes straight to HOLD.
- cnt never exceeds LEN-1 in ACCUM.

## Configuration
- PRODUCT_ACC_SATURATE_EN defined: on carry out, acc <= all-ones (2^ACC_W-1) and ovf <= 1. Later adds in the frame keep acc at all-ones.
- Not defined: acc wraps modulo 2^ACC_W and ovf <= 1.
- Handshake and timing are identical in both builds.

## Test plan
- Basic frame, LEN=4, ACC_W=8: beats P=9,6,4,2 on consecutive cycles, out_ready=1 → out_valid high the cycle after beat 4, sum=21, ovf=0, in_ready=1 two cycles after the last beat.
- Bubbles and backpressure: LEN=4; beats 1,2,3,4 with idle cycles between; out_ready held 0 for 5 cycles → out_valid high, sum=10 held stable and in_ready=0 throughout; consumed on the first out_ready=1 cycle.
- Overflow, ACC_W=5, LEN=4: beats 9,9,9,9 (true sum 36) → without macro sum=4, ovf=1; with PRODUCT_ACC_SATURATE_EN sum=31, ovf=1. After consume, the next frame 1,1,1,1 gives sum=4, ovf=0.
- clr mid-frame: LEN=4; beats 9,9, then clr asserted together with beat P=5 → P=5 dropped, acc=0. Next beats 1,2,3,4 give sum=10.
- clr in HOLD: result 21 pending, clr=1 with out_ready=0 → out_valid=0 next cycle, sum=0, in_ready=1.
- Reset mid-operation: rst pulsed for one cycle after 2 beats → all outputs at reset values, in_ready=0 during rst. A fresh frame 2,2,2,2 then gives sum=8.

Source files
------------

// File: rtl/product_accumulator.sv
// Sums frames of LEN 4-bit multiplier products into an ACC_W-bit result with valid/ready output.
// Define PRODUCT_ACC_SATURATE_EN to clamp on overflow instead of wrapping.
module product_accumulator #(
  parameter int unsigned ACC_W = 8,
  parameter int unsigned LEN   = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [3:0]       i_p,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [ACC_W-1:0] o_sum,
  output logic             o_ovf
);

  typedef enum logic {StAccum, StHold} state_e;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_acc_nxt;
  logic [3:0]       r_cnt;
  logic [3:0]       w_cnt_nxt;
  logic             r_ovf;
  logic             w_ovf_nxt;

  logic [ACC_W:0]   w_sum_ext;
  logic             w_carry;
  logic [ACC_W-1:0] w_add;
  logic             w_accept;

  assign o_in_ready  = (r_state == StAccum) && !i_rst;
  assign o_out_valid = (r_state == StHold);
  assign o_sum       = r_acc;
  assign o_ovf       = r_ovf;

  assign w_accept  = i_in_valid && o_in_ready;
  assign w_sum_ext = {1'b0, r_acc} + (ACC_W+1)'(i_p);
  assign w_carry   = w_sum_ext[ACC_W];

`ifdef PRODUCT_ACC_SATURATE_EN
  // Once at all-ones, any nonzero add carries again, so the clamp is self-sustaining.
  assign w_add = w_carry ? {ACC_W{1'b1}} : w_sum_ext[ACC_W-1:0];
`else
  assign w_add = w_sum_ext[ACC_W-1:0];
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_ovf_nxt   = r_ovf;
    if (i_clr) begin
      w_state_nxt = StAccum;
      w_acc_nxt   = '0;
      w_cnt_nxt   = '0;
      w_ovf_nxt   = 1'b0;
    end else begin
      unique case (r_state)
        StAccum: begin
          if (w_accept) begin
            w_acc_nxt = w_add;
            w_cnt_nxt = r_cnt + 4'd1;
            w_ovf_nxt = r_ovf | w_carry;
            if (r_cnt == 4'(LEN - 1)) w_state_nxt = StHold;
          end
        end
        StHold: begin
          if (i_out_ready) begin
            w_state_nxt = StAccum;
            w_acc_nxt   = '0;
            w_cnt_nxt   = '0;
            w_ovf_nxt   = 1'b0;
          end
        end
        default: w_state_nxt = StAccum;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StAccum;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench: default, narrow (ACC_W=5) and LEN=1 accumulators driven by hand-computed vectors.
module tb_product_accumulator;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // A: ACC_W=8, LEN=4
  logic       a_clr, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_ovf;
  logic [3:0] a_p;
  logic [7:0] a_sum;
  // B: ACC_W=5, LEN=4
  logic       b_clr, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_ovf;
  logic [3:0] b_p;
  logic [4:0] b_sum;
  // C: ACC_W=8, LEN=1
  logic       c_clr, c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_ovf;
  logic [3:0] c_p;
  logic [7:0] c_sum;

  int n_checks = 0;
  int n_fail   = 0;

  product_accumulator #(.ACC_W(8), .LEN(4)) u_a (
    .i_clk(clk), .i_rst(rst), .i_clr(a_clr), .i_in_valid(a_in_valid), .o_in_ready(a_in_ready),
    .i_p(a_p), .o_out_valid(a_out_valid), .i_out_ready(a_out_ready), .o_sum(a_sum), .o_ovf(a_ovf)
  );
  product_accumulator #(.ACC_W(5), .LEN(4)) u_b (
    .i_clk(clk), .i_rst(rst), .i_clr(b_clr), .i_in_valid(b_in_valid), .o_in_ready(b_in_ready),
    .i_p(b_p), .o_out_valid(b_out_valid), .i_out_ready(b_out_ready), .o_sum(b_sum), .o_ovf(b_ovf)
  );
  product_accumulator #(.ACC_W(8), .LEN(1)) u_c (
    .i_clk(clk), .i_rst(rst), .i_clr(c_clr), .i_in_valid(c_in_valid), .o_in_ready(c_in_ready),
    .i_p(c_p), .o_out_valid(c_out_valid), .i_out_ready(c_out_ready), .o_sum(c_sum), .o_ovf(c_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat_a(input logic [3:0] p);
    a_in_valid = 1'b1;
    a_p        = p;
    tick();
    a_in_valid = 1'b0;
  endtask

  task automatic beat_b(input logic [3:0] p);
    b_in_valid = 1'b1;
    b_p        = p;
    tick();
    b_in_valid = 1'b0;
  endtask

  task automatic chk_a(input string tag, input logic vld, input logic [7:0] s, input logic o,
                       input logic rdy);
    chk({tag, ".out_valid"}, 32'(a_out_valid), 32'(vld));
    chk({tag, ".sum"},       32'(a_sum),       32'(s));
    chk({tag, ".ovf"},       32'(a_ovf),       32'(o));
    chk({tag, ".in_ready"},  32'(a_in_ready),  32'(rdy));
  endtask

  initial begin
    logic [4:0] ovf_sum;
`ifdef PRODUCT_ACC_SATURATE_EN
    ovf_sum = 5'd31;
`else
    ovf_sum = 5'd4;
`endif
    rst = 1'b1;
    a_clr = 0; a_in_valid = 0; a_p = 0; a_out_ready = 0;
    b_clr = 0; b_in_valid = 0; b_p = 0; b_out_ready = 0;
    c_clr = 0; c_in_valid = 0; c_p = 0; c_out_ready = 0;
    #1;
    chk("rst_in_ready_low", 32'(a_in_ready), 32'd0);
    tick();
    chk_a("reset", 1'b0, 8'd0, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(a_in_ready), 32'd1);

    // Basic frame
    a_out_ready = 1'b1;
    beat_a(4'd9); beat_a(4'd6); beat_a(4'd4);
    chk_a("basic_mid", 1'b0, 8'd19, 1'b0, 1'b1);
    beat_a(4'd2);
    chk_a("basic_done", 1'b1, 8'd21, 1'b0, 1'b0);
    tick();
    chk_a("basic_consumed", 1'b0, 8'd0, 1'b0, 1'b1);

    // Bubbles and backpressure
    a_out_ready = 1'b0;
    beat_a(4'd1); tick(); beat_a(4'd2); tick(); beat_a(4'd3); tick();
    chk_a("bubble_mid", 1'b0, 8'd6, 1'b0, 1'b1);
    beat_a(4'd4);
    chk_a("bubble_done", 1'b1, 8'd10, 1'b0, 1'b0);
    a_in_valid = 1'b1;
    a_p        = 4'd7;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_a("backpressure", 1'b1, 8'd10, 1'b0, 1'b0);
    end
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    tick();
    chk_a("bp_consumed", 1'b0, 8'd0, 1'b0, 1'b1);
    a_out_ready = 1'b0;

    // clr mid-frame drops the concurrent beat
    beat_a(4'd9); beat_a(4'd9);
    a_clr = 1'b1;
    beat_a(4'd5);
    a_clr = 1'b0;
    chk_a("clr_mid", 1'b0, 8'd0, 1'b0, 1'b1);
    beat_a(4'd1); beat_a(4'd2); beat_a(4'd3); beat_a(4'd4);
    chk_a("after_clr", 1'b1, 8'd10, 1'b0, 1'b0);
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
    beat_a(4'd9); beat_a(4'd6); beat_a(4'd4); beat_a(4'd2);
    chk_a("hold_pending", 1'b1, 8'd21, 1'b0, 1'b0);

    // clr in HOLD discards the pending result
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    chk_a("clr_hold", 1'b0, 8'd0, 1'b0, 1'b1);

    // Reset mid-operation
    beat_a(4'd2); beat_a(4'd2);
    rst = 1'b1;
    #1;
    chk("rst_mid_in_ready", 32'(a_in_ready), 32'd0);
    tick();
    chk_a("rst_mid", 1'b0, 8'd0, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    beat_a(4'd2); beat_a(4'd2); beat_a(4'd2); beat_a(4'd2);
    chk_a("after_rst", 1'b1, 8'd8, 1'b0, 1'b0);

    // Overflow on the 5-bit accumulator
    beat_b(4'd9); beat_b(4'd9); beat_b(4'd9);
    chk("ovf_pre.sum", 32'(b_sum), 32'd27);
    chk("ovf_pre.ovf", 32'(b_ovf), 32'd0);
    beat_b(4'd9);
    chk("ovf.out_valid", 32'(b_out_valid), 32'd1);
    chk("ovf.sum", 32'(b_sum), 32'(ovf_sum));
    chk("ovf.ovf", 32'(b_ovf), 32'd1);
    b_out_ready = 1'b1;
    tick();
    b_out_ready = 1'b0;
    chk("ovf_consumed.ovf", 32'(b_ovf), 32'd0);
    beat_b(4'd1); beat_b(4'd1); beat_b(4'd1); beat_b(4'd1);
    chk("ovf_next.sum", 32'(b_sum), 32'd4);
    chk("ovf_next.ovf", 32'(b_ovf), 32'd0);
    chk("ovf_next.out_valid", 32'(b_out_valid), 32'd1);

    // LEN=1: each beat completes a frame
    c_in_valid = 1'b1;
    c_p        = 4'd7;
    tick();
    chk("len1.out_valid", 32'(c_out_valid), 32'd1);
    chk("len1.sum", 32'(c_sum), 32'd7);
    chk("len1.in_ready", 32'(c_in_ready), 32'd0);
    c_out_ready = 1'b1;
    c_p         = 4'd3;
    tick();
    chk("len1_consumed.out_valid", 32'(c_out_valid), 32'd0);
    tick();
    chk("len1_second.sum", 32'(c_sum), 32'd3);
    chk("len1_second.out_valid", 32'(c_out_valid), 32'd1);
    c_in_valid = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
